// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake.
//
// A two-entry skid buffer (main + skid) gives full throughput under
// back-pressure without a combinational path from out_ready to in_ready.
// Adds synchronous flush, bubble-safe control gating and a saturating
// back-pressure cycle counter.
//
// Build option:
//   EX_MEM_BRANCH_RESOLVE_EN  when defined, a branch decision is resolved
//                             as a payload is loaded into the main entry and
//                             driven on branch_taken; otherwise branch_taken
//                             is tied 0 and no decode logic exists.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous kill of all held entries and input
//   in_valid / in_ready     EX-side handshake
//   RegWrite .. rd          EX payload (control bits, results, funct, rd)
//   out_valid / out_ready   MEM-side handshake
//   *_store                 registered payload; write/branch controls read 0
//                           while out_valid is low
//   branch_taken            registered branch decision (gated by out_valid)
//   stall_cnt               saturating count of out_valid && !out_ready cycles

module ex_mem_pipe_reg #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FUNCT_W     = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,

  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   RegWrite,
  input  logic                   MemtoReg,
  input  logic                   Branch,
  input  logic                   Zero,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic                   Is_Greater,
  input  logic [XLEN-1:0]        PCplusimm,
  input  logic [XLEN-1:0]        ALU_result,
  input  logic [XLEN-1:0]        WriteData,
  input  logic [FUNCT_W-1:0]     funct_in,
  input  logic [REG_AW-1:0]      rd,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   RegWrite_store,
  output logic                   MemtoReg_store,
  output logic                   Branch_store,
  output logic                   Zero_store,
  output logic                   MemWrite_store,
  output logic                   MemRead_store,
  output logic                   Is_Greater_store,
  output logic [XLEN-1:0]        PCplusimm_store,
  output logic [XLEN-1:0]        ALU_result_store,
  output logic [XLEN-1:0]        WriteData_store,
  output logic [FUNCT_W-1:0]     funct_in_store,
  output logic [REG_AW-1:0]      rd_store,
  output logic                   branch_taken,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               zero;
    logic               mem_write;
    logic               mem_read;
    logic               is_greater;
    logic [XLEN-1:0]    pc_plus_imm;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    write_data;
    logic [FUNCT_W-1:0] funct;
    logic [REG_AW-1:0]  rd;
  } payload_t;

  payload_t in_p;
  payload_t main_p_q, main_p_d;
  payload_t skid_p_q, skid_p_d;
  logic     main_v_q, main_v_d;
  logic     skid_v_q, skid_v_d;
  logic     accept, consume;
  logic     load_main;
  payload_t load_p;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_p = '{
    reg_write:   RegWrite,
    mem_to_reg:  MemtoReg,
    branch:      Branch,
    zero:        Zero,
    mem_write:   MemWrite,
    mem_read:    MemRead,
    is_greater:  Is_Greater,
    pc_plus_imm: PCplusimm,
    alu_result:  ALU_result,
    write_data:  WriteData,
    funct:       funct_in,
    rd:          rd
  };

  // in_ready depends only on registered state so MEM back-pressure never
  // ripples combinationally into EX.
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = main_v_q & out_ready;

  always_comb begin
    main_v_d  = main_v_q;
    main_p_d  = main_p_q;
    skid_v_d  = skid_v_q;
    skid_p_d  = skid_p_q;
    load_main = 1'b0;
    load_p    = skid_p_q;

    if (flush) begin
      // Payload registers keep their contents; only the valid bits drop.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || consume) begin
      if (skid_v_q) begin
        load_main = 1'b1;
        load_p    = skid_p_q;
        skid_v_d  = accept;
        if (accept) begin
          skid_p_d = in_p;
        end
      end else if (accept) begin
        load_main = 1'b1;
        load_p    = in_p;
      end
      main_v_d = load_main;
      if (load_main) begin
        main_p_d = load_p;
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_p_d = in_p;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_p_q    <= '0;
      skid_p_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_p_q    <= main_p_d;
      skid_p_q    <= skid_p_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  // Resolved once on load so the MEM stage sees a registered decision.
  function automatic logic resolve_branch(input payload_t p);
    logic taken;
    unique case (p.funct[2:0])
      3'b000:  taken = p.zero;
      3'b001:  taken = ~p.zero;
      3'b100:  taken = ~p.is_greater & ~p.zero;
      3'b101:  taken = p.is_greater | p.zero;
      default: taken = 1'b0;
    endcase
    return p.branch & taken;
  endfunction

  logic main_bt_q, main_bt_d;

  always_comb begin
    main_bt_d = main_bt_q;
    if (!flush && load_main) begin
      main_bt_d = resolve_branch(load_p);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_bt_q <= 1'b0;
    end else begin
      main_bt_q <= main_bt_d;
    end
  end

  assign branch_taken = main_bt_q & main_v_q;
`else
  assign branch_taken = 1'b0;
`endif

  // Controls with side effects read 0 during bubbles.
  assign RegWrite_store   = main_p_q.reg_write & main_v_q;
  assign MemWrite_store   = main_p_q.mem_write & main_v_q;
  assign MemRead_store    = main_p_q.mem_read & main_v_q;
  assign Branch_store     = main_p_q.branch & main_v_q;
  assign MemtoReg_store   = main_p_q.mem_to_reg;
  assign Zero_store       = main_p_q.zero;
  assign Is_Greater_store = main_p_q.is_greater;
  assign PCplusimm_store  = main_p_q.pc_plus_imm;
  assign ALU_result_store = main_p_q.alu_result;
  assign WriteData_store  = main_p_q.write_data;
  assign funct_in_store   = main_p_q.funct;
  assign rd_store         = main_p_q.rd;
  assign stall_cnt        = stall_cnt_q;

endmodule
